// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
//   Bundles the timing outputs of video_timing_gen.
//   master : driven by the timing generator.
//   slave  : consumed by downstream pixel pipelines.
// Signals:
//   DE            data enable (visible pixel)
//   HSYNC/VSYNC   sync outputs at their configured polarity
//   hCount/vCount current pixel column / line
//   frameStart    one-output pulse at pixel (0,0)
//   lineStart     one-output pulse at column 0
//   overlayActive overlay window pixel strobe
//   overlayAddr   linear overlay-image address
interface video_timing_gen_if #(
    parameter int hBusWidth = 12,
    parameter int vBusWidth = 12,
    parameter int ADDR_W    = 24
);
    logic                 DE;
    logic                 HSYNC;
    logic                 VSYNC;
    logic [hBusWidth-1:0] hCount;
    logic [vBusWidth-1:0] vCount;
    logic                 frameStart;
    logic                 lineStart;
    logic                 overlayActive;
    logic [ADDR_W-1:0]    overlayAddr;

    modport master (
        output DE, HSYNC, VSYNC, hCount, vCount,
               frameStart, lineStart, overlayActive, overlayAddr
    );

    modport slave (
        input  DE, HSYNC, VSYNC, hCount, vCount,
               frameStart, lineStart, overlayActive, overlayAddr
    );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator. Internal (h,v) counters advance one pixel per
//   clock with pixelEnable high; every output is registered from the
//   pre-increment (h,v) of the same enabled edge, so all outputs are aligned
//   and lag the counters by one enabled cycle.
// Ports:
//   clock          single clock
//   masterReset_n  synchronous active-low reset
//   pixelEnable    advances timing one pixel when high; all state holds when low
//   vid            video_timing_gen_if.master timing outputs
// Optional feature:
//   VTG_OVERLAY_WINDOW_EN  when defined, drives overlayActive/overlayAddr from
//   a window (OVL_X,OVL_Y,OVL_W,OVL_H) clipped to the active area; when
//   undefined both are constant 0 and no window logic exists.
module video_timing_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int hBusWidth = 12,
    parameter int vBusWidth = 12,
    parameter int OVL_X     = 0,
    parameter int OVL_Y     = 0,
    parameter int OVL_W     = 320,
    parameter int OVL_H     = 240,
    parameter int ADDR_W    = 24
) (
    input  logic                clock,
    input  logic                masterReset_n,
    input  logic                pixelEnable,
    video_timing_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL >= (1 << hBusWidth)) begin : g_bad_h
        $error("video_timing_gen: H_TOTAL does not fit in hBusWidth");
    end
    if (V_TOTAL >= (1 << vBusWidth)) begin : g_bad_v
        $error("video_timing_gen: V_TOTAL does not fit in vBusWidth");
    end

    localparam logic [hBusWidth-1:0] H_LAST   = hBusWidth'(H_TOTAL - 1);
    localparam logic [hBusWidth-1:0] H_ACT    = hBusWidth'(H_ACTIVE);
    localparam logic [hBusWidth-1:0] HS_START = hBusWidth'(H_ACTIVE + H_FP);
    localparam logic [hBusWidth-1:0] HS_END   = hBusWidth'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [vBusWidth-1:0] V_LAST   = vBusWidth'(V_TOTAL - 1);
    localparam logic [vBusWidth-1:0] V_ACT    = vBusWidth'(V_ACTIVE);
    localparam logic [vBusWidth-1:0] VS_START = vBusWidth'(V_ACTIVE + V_FP);
    localparam logic [vBusWidth-1:0] VS_END   = vBusWidth'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [hBusWidth-1:0] h, h_next;
    logic [vBusWidth-1:0] v, v_next;
    logic de_d, hs_d, vs_d, fs_d, ls_d;

    always_comb begin
        h_next = h;
        v_next = v;
        if (h == H_LAST) begin
            h_next = '0;
            v_next = (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h_next = h + 1'b1;
        end
    end

    always_comb begin
        de_d = (h < H_ACT) && (v < V_ACT);
        hs_d = ((h >= HS_START) && (h < HS_END)) ? HS_ON : ~HS_ON;
        vs_d = ((v >= VS_START) && (v < VS_END)) ? VS_ON : ~VS_ON;
        ls_d = (h == '0);
        fs_d = (h == '0) && (v == '0);
    end

    always_ff @(posedge clock) begin
        if (!masterReset_n) begin
            h              <= '0;
            v              <= '0;
            vid.DE         <= 1'b0;
            vid.HSYNC      <= ~HS_ON;
            vid.VSYNC      <= ~VS_ON;
            vid.hCount     <= '0;
            vid.vCount     <= '0;
            vid.frameStart <= 1'b0;
            vid.lineStart  <= 1'b0;
        end else if (pixelEnable) begin
            h              <= h_next;
            v              <= v_next;
            vid.DE         <= de_d;
            vid.HSYNC      <= hs_d;
            vid.VSYNC      <= vs_d;
            vid.hCount     <= h;
            vid.vCount     <= v;
            vid.frameStart <= fs_d;
            vid.lineStart  <= ls_d;
        end
    end

`ifdef VTG_OVERLAY_WINDOW_EN
    // Window bounds clipped to the active area so they always fit the counters.
    localparam int OX0 = (OVL_X < H_ACTIVE) ? OVL_X : H_ACTIVE;
    localparam int OX1 = (OVL_X + OVL_W < H_ACTIVE) ? OVL_X + OVL_W : H_ACTIVE;
    localparam int OY0 = (OVL_Y < V_ACTIVE) ? OVL_Y : V_ACTIVE;
    localparam int OY1 = (OVL_Y + OVL_H < V_ACTIVE) ? OVL_Y + OVL_H : V_ACTIVE;
    localparam logic [hBusWidth-1:0] OX0_B = hBusWidth'(OX0);
    localparam logic [hBusWidth-1:0] OX1_B = hBusWidth'(OX1);
    localparam logic [vBusWidth-1:0] OY0_B = vBusWidth'(OY0);
    localparam logic [vBusWidth-1:0] OY1_B = vBusWidth'(OY1);

    logic ov_d;

    always_comb begin
        ov_d = de_d && (h >= OX0_B) && (h < OX1_B) && (v >= OY0_B) && (v < OY1_B);
    end

    // The address steps after each active output, using the registered
    // overlayActive of the previous output; the (0,0) output forces it to 0.
    always_ff @(posedge clock) begin
        if (!masterReset_n) begin
            vid.overlayActive <= 1'b0;
            vid.overlayAddr   <= '0;
        end else if (pixelEnable) begin
            vid.overlayActive <= ov_d;
            if (fs_d) begin
                vid.overlayAddr <= '0;
            end else if (vid.overlayActive) begin
                vid.overlayAddr <= vid.overlayAddr + 1'b1;
            end
        end
    end
`else
    assign vid.overlayActive = 1'b0;
    assign vid.overlayAddr   = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = 16;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
    localparam int OX = 2, OY = 1, OW = 3, OH = 2;
    localparam int FRAME = HT * VT;

    logic clock = 1'b0;
    logic masterReset_n = 1'b0;
    logic pixelEnable = 1'b0;

    always #5 clock = ~clock;

    video_timing_gen_if #(.hBusWidth(12), .vBusWidth(12), .ADDR_W(24)) vid_p ();
    video_timing_gen_if #(.hBusWidth(12), .vBusWidth(12), .ADDR_W(24)) vid_n ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1), .VSYNC_POL(1), .hBusWidth(12), .vBusWidth(12),
        .OVL_X(OX), .OVL_Y(OY), .OVL_W(OW), .OVL_H(OH), .ADDR_W(24)
    ) dut_p (
        .clock(clock), .masterReset_n(masterReset_n),
        .pixelEnable(pixelEnable), .vid(vid_p)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .hBusWidth(12), .vBusWidth(12),
        .OVL_X(OX), .OVL_Y(OY), .OVL_W(OW), .OVL_H(OH), .ADDR_W(24)
    ) dut_n (
        .clock(clock), .masterReset_n(masterReset_n),
        .pixelEnable(pixelEnable), .vid(vid_n)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] hc;
        logic [11:0] vc;
        logic        fs;
        logic        ls;
        logic        oa;
        logic [23:0] oaddr;
    } out_t;

    out_t act_p, act_n;
    assign act_p = {vid_p.DE, vid_p.HSYNC, vid_p.VSYNC, vid_p.hCount, vid_p.vCount,
                    vid_p.frameStart, vid_p.lineStart, vid_p.overlayActive, vid_p.overlayAddr};
    assign act_n = {vid_n.DE, vid_n.HSYNC, vid_n.VSYNC, vid_n.hCount, vid_n.vCount,
                    vid_n.frameStart, vid_n.lineStart, vid_n.overlayActive, vid_n.overlayAddr};

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: raster position index within the frame.
    bit m_valid = 1'b0;   // an enabled edge has produced an output since reset
    int m_next  = 0;      // position the next enabled edge will output
    int m_out   = 0;      // position currently shown on the outputs

    function automatic bit in_win(int h, int v);
        return (h < HA) && (v < VA) && (h >= OX) && (h < OX + OW) &&
               (v >= OY) && (v < OY + OH);
    endfunction

    function automatic out_t model(bit valid, int pos, bit pol);
        out_t e;
        int h, v, cnt;
        e = '0;
        e.hs = ~pol;
        e.vs = ~pol;
        if (valid) begin
            h = pos % HT;
            v = pos / HT;
            e.de = (h < HA) && (v < VA);
            e.hs = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
            e.vs = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
            e.hc = 12'(h);
            e.vc = 12'(v);
            e.fs = (pos == 0);
            e.ls = (h == 0);
`ifdef VTG_OVERLAY_WINDOW_EN
            // Address = number of window pixels earlier in this frame.
            cnt = 0;
            for (int q = 0; q < pos; q++) begin
                if (in_win(q % HT, q / HT)) cnt++;
            end
            e.oa = in_win(h, v);
            e.oaddr = 24'(cnt);
`else
            cnt = 0;
            e.oaddr = 24'(cnt);
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic check_out(input string name, input out_t act, input out_t exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual de=%b hs=%b vs=%b h=%0d v=%0d fs=%b ls=%b oa=%b addr=%0d required de=%b hs=%b vs=%b h=%0d v=%0d fs=%b ls=%b oa=%b addr=%0d",
                      name, act.de, act.hs, act.vs, act.hc, act.vc, act.fs, act.ls, act.oa, act.oaddr,
                      exp.de, exp.hs, exp.vs, exp.hc, exp.vc, exp.fs, exp.ls, exp.oa, exp.oaddr);
    endtask

    // Apply inputs, take one edge, update the model and compare both DUTs.
    task automatic step(input logic rst_n, input logic en);
        masterReset_n = rst_n;
        pixelEnable   = en;
        @(posedge clock);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_next  = 0;
            m_out   = 0;
        end else if (en) begin
            m_valid = 1'b1;
            m_out   = m_next;
            m_next  = (m_next + 1) % FRAME;
        end
        #1;
        check_out("model_pos", act_p, model(m_valid, m_out, 1'b1));
        check_out("model_neg", act_n, model(m_valid, m_out, 1'b0));
    endtask

    typedef struct {
        logic rst_n;
        logic en;
        int   hc;
        int   vc;
        logic de;
        logic fs;
        logic ls;
    } vec_t;

    vec_t vecs[7];

    int n_de, n_hs, n_hs_out, n_vs, n_fs, n_ls, n_oa, n_de_blank;

    initial begin
        // Reset, then pixelEnable pattern 1,0,0,1,1,0 from a fresh frame.
        vecs[0] = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0};

        #1;
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].rst_n, vecs[i].en);
            check("table", {act_p.hc, act_p.vc, act_p.de, act_p.fs, act_p.ls},
                  {12'(vecs[i].hc), 12'(vecs[i].vc), vecs[i].de, vecs[i].fs, vecs[i].ls});
        end

        // One full frame of continuous enable, counting output classes.
        step(1'b0, 1'b0);
        n_de = 0; n_hs = 0; n_hs_out = 0; n_vs = 0; n_fs = 0; n_ls = 0; n_oa = 0; n_de_blank = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 1'b1);
            n_de += int'(act_p.de);
            n_hs += int'(act_p.hs);
            if (act_p.hs && (act_p.hc < 10 || act_p.hc > 12)) n_hs_out++;
            n_vs += int'(act_p.vs);
            n_fs += int'(act_p.fs);
            n_ls += int'(act_p.ls);
            n_oa += int'(act_p.oa);
            if (act_p.de && act_p.vc >= 4) n_de_blank++;
        end
        check("frame_de_count", 64'(n_de), 64'(32));
        check("frame_hsync_count", 64'(n_hs), 64'(24));
        check("hsync_outside_10_12", 64'(n_hs_out), 64'(0));
        check("frame_vsync_count", 64'(n_vs), 64'(32));
        check("frame_fs_count", 64'(n_fs), 64'(1));
        check("frame_ls_count", 64'(n_ls), 64'(8));
        check("de_in_blank_lines", 64'(n_de_blank), 64'(0));
`ifdef VTG_OVERLAY_WINDOW_EN
        check("frame_overlay_count", 64'(n_oa), 64'(6));
`else
        check("frame_overlay_count", 64'(n_oa), 64'(0));
`endif
        step(1'b1, 1'b1);
        check("next_frame_start", {act_p.fs, act_p.hc, act_p.vc, act_p.oaddr},
              {1'b1, 12'd0, 12'd0, 24'd0});

        // Mid-frame reset at (5,2), then restart at (0,0).
        step(1'b0, 1'b0);
        for (int i = 0; i < 38; i++) step(1'b1, 1'b1);
        check("pre_reset_pos", {act_p.hc, act_p.vc}, {12'd5, 12'd2});
        step(1'b0, 1'b1);
        check("reset_values", act_p, {1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 24'd0});
        check("reset_values_neg_pol", {act_n.hs, act_n.vs}, {1'b1, 1'b1});
        step(1'b1, 1'b1);
        check("restart_pixel", {act_p.hc, act_p.vc, act_p.fs, act_p.ls, act_p.de},
              {12'd0, 12'd0, 1'b1, 1'b1, 1'b1});

        // Randomised enable with occasional reset, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
